// File: rtl/decodificador_constante_pkg.sv
// Shared types for the decode stage feeding the constant extender.
// Optional illegal-word flag is enabled with DECODIFICADOR_ILEGAL_EN.
package pacote_decod;

  localparam int LARG_CONST = 11;
  localparam logic [4:0] OP_ALU_MAX = 5'b10011;

  typedef enum logic [1:0] {
    EXT_LOADLIT = 2'b00,
    EXT_LCL     = 2'b01,
    EXT_LCH     = 2'b10,
    EXT_NENHUM  = 2'b11
  } controle_e;

  typedef enum logic [1:0] {
    FMT_ALU     = 2'b00,
    FMT_OUTRO   = 2'b01,
    FMT_LOADLIT = 2'b10,
    FMT_LCL_LCH = 2'b11
  } formato_e;

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } estado_e;

  typedef struct packed {
    logic [LARG_CONST-1:0] constante;
    controle_e             controle;
    logic [2:0]            regA;
    logic [2:0]            regB;
    logic [2:0]            regC;
    logic [4:0]            opALU;
    logic                  ehALU;
`ifdef DECODIFICADOR_ILEGAL_EN
    logic                  ilegal;
`endif
  } campos_decod_t;

  // Idle value of a slot: everything zero except "no extension".
  function automatic campos_decod_t campos_neutros();
    campos_decod_t c;
    c          = '0;
    c.controle = EXT_NENHUM;
    return c;
  endfunction

endpackage

// File: rtl/decodificador_constante_campos.sv
// Purely combinational split of an instruction word into decoded fields.
// With DECODIFICADOR_ILEGAL_EN, reserved encodings are flagged and neutralised.
module decod_campos
  import pacote_decod::*;
(
  input  logic [15:0]   instrucao,
  output campos_decod_t campos
);

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    campos = campos_neutros();
    case (instrucao[15:14])
      FMT_ALU: begin
        campos.opALU = instrucao[13:9];
        campos.regA  = instrucao[8:6];
        campos.regB  = instrucao[5:3];
        campos.regC  = instrucao[2:0];
        campos.ehALU = 1'b1;
      end
      FMT_OUTRO: begin
        campos.regA      = instrucao[13:11];
        campos.regB      = instrucao[10:8];
        campos.constante = {3'b000, instrucao[7:0]};
      end
      FMT_LOADLIT: begin
        campos.regC      = instrucao[13:11];
        campos.constante = instrucao[10:0];
        campos.controle  = EXT_LOADLIT;
      end
      default: begin
        campos.regC      = instrucao[10:8];
        campos.constante = {3'b000, instrucao[7:0]};
        campos.controle  = instrucao[13] ? EXT_LCH : EXT_LCL;
      end
    endcase
`ifdef DECODIFICADOR_ILEGAL_EN
    campos.ilegal = ((instrucao[15:14] == FMT_LCL_LCH) && (instrucao[12:11] != 2'b00)) ||
                    ((instrucao[15:14] == FMT_ALU) && (instrucao[13:9] > OP_ALU_MAX));
    if (campos.ilegal) begin
      campos.controle  = EXT_NENHUM;
      campos.constante = '0;
    end
`endif
  end

endmodule

// File: rtl/decodificador_constante.sv
// Decode stage with a two-slot skid buffer and registered prontoEntrada.
// Build option: DECODIFICADOR_ILEGAL_EN adds the ilegal output.
module decodificador_constante
  import pacote_decod::*;
#(
  parameter int LARGURA_INSTR = 16,
  parameter int LARGURA_CONST = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LARGURA_INSTR-1:0] instrucao,
  input  logic                     validoEntrada,
  output logic                     prontoEntrada,
  input  logic                     descarte,
  output logic [LARGURA_CONST-1:0] constante,
  output logic [1:0]               controle,
  output logic [2:0]               regC,
  output logic [2:0]               regA,
  output logic [2:0]               regB,
  output logic [4:0]               opALU,
  output logic                     ehALU,
  output logic                     validoSaida,
  input  logic                     prontoSaida
`ifdef DECODIFICADOR_ILEGAL_EN
  ,
  output logic                     ilegal
`endif
);

  estado_e       estado_q, estado_d;
  campos_decod_t saida_q, skid_q, campos_novo;
  logic          valido_q, pronto_q;
  logic          entra, sai;

  decod_campos u_decod (
    .instrucao (instrucao),
    .campos    (campos_novo)
  );

  assign entra = validoEntrada && pronto_q;
  assign sai   = valido_q && prontoSaida;

  always_comb begin
    estado_d = estado_q;
    if (descarte) begin
      estado_d = VAZIO;
    end else begin
      case (estado_q)
        VAZIO:   if (entra) estado_d = UM;
        UM: begin
          if (entra && !sai)      estado_d = CHEIO;
          else if (!entra && sai) estado_d = VAZIO;
        end
        CHEIO:   if (sai) estado_d = UM;
        default: estado_d = VAZIO;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= VAZIO;
      valido_q <= 1'b0;
      pronto_q <= 1'b1;
      // NOTE: data slots are reset too, because the outputs must read zero after reset.
      saida_q  <= campos_neutros();
      skid_q   <= campos_neutros();
    end else begin
      estado_q <= estado_d;
      valido_q <= (estado_d != VAZIO);
      pronto_q <= (estado_d != CHEIO);
      if (!descarte) begin
        case (estado_q)
          VAZIO: if (entra) saida_q <= campos_novo;
          UM: begin
            if (entra && sai) saida_q <= campos_novo;
            else if (entra)   skid_q  <= campos_novo;
          end
          CHEIO: if (sai) saida_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign prontoEntrada = pronto_q;
  assign validoSaida   = valido_q;
  assign constante     = saida_q.constante;
  assign controle      = saida_q.controle;
  assign regC          = saida_q.regC;
  assign regA          = saida_q.regA;
  assign regB          = saida_q.regB;
  assign opALU         = saida_q.opALU;
  assign ehALU         = saida_q.ehALU;
`ifdef DECODIFICADOR_ILEGAL_EN
  assign ilegal        = saida_q.ilegal;
`endif

endmodule

// File: doc/decodificador_constante.md
Name: decodificador_constante

Overview:
- Decode stage directly upstream of the constant extender in the 16-bit datapath.
- Accepts fetched 16-bit instruction words over a valid/ready handshake.
- Splits each word into the 11-bit `constante` field and 2-bit `controle` code the extender consumes, plus register addresses and ALU opcode.
- Two-entry skid buffer: upstream `prontoEntrada` is registered, and downstream stalls never drop or duplicate instructions.

Parameters:
- LARGURA_INSTR, 16, instruction word width; only 16 supported.
- LARGURA_CONST, 11, width of `constante` output.

Ports:
- clock  input  1  single rising-edge clock
- reset  input  1  synchronous, active-high reset
- instrucao  input  16  fetched instruction word
- validoEntrada  input  1  instrucao valid
- prontoEntrada  output  1  stage can accept a word this cycle (registered)
- descarte  input  1  flush: discard all buffered words
- constante  output  11  constant field for extender
- controle  output  2  extender mode: 00 loadlit, 01 lcl, 10 lch, 11 none
- regC  output  3  destination register
- regA  output  3  source A
- regB  output  3  source B
- opALU  output  5  ALU opcode (00000 when not ALU format)
- ehALU  output  1  word is ALU format
- validoSaida  output  1  decoded outputs valid
- prontoSaida  input  1  downstream accepts this cycle

Behaviour:
- Formats are selected by instrucao[15:14]:
  - 00 ALU: opALU=[13:9], regA=[8:6], regB=[5:3], regC=[2:0], constante=0, controle=11, ehALU=1.
  - 01 other (memory/jump): regA=[13:11], regB=[10:8], regC=0, constante={3'b000,[7:0]}, controle=11.
  - 10 loadlit: regC=[13:11], constante=[10:0] (raw, sign bit at [10]), controle=00.
  - 11 lcl/lch: bit[13]=0 gives lcl (controle=01), bit[13]=1 gives lch (controle=10); regC=[10:8], constante={3'b000,[7:0]}.
  - Bits not named in a format are don't-care and produce no effect.
- Decode logic is combinational on the buffer write path; decoded fields are stored, never recomputed on the output side.
- Latency: 1 cycle. A word accepted at edge N appears with validoSaida=1 after edge N.
- Handshake:
  - Transfer in when validoEntrada && prontoEntrada.
  - Transfer out when validoSaida && prontoSaida.
  - Outputs hold stable while validoSaida=1 && prontoSaida=0.
- Buffer FSM:
  - VAZIO: validoSaida=0, prontoEntrada=1. An input transfer goes to UM.
  - UM: validoSaida=1, prontoEntrada=1.
    - Input and output transfer together: stay in UM with the new word.
    - Input transfer only: go to CHEIO, new word goes to the skid slot.
    - Output transfer only: go to VAZIO.
  - CHEIO: validoSaida=1, prontoEntrada=0.
    - Output transfer: skid word moves to the output slot, go to UM.
    - validoEntrada is ignored in CHEIO.
- prontoEntrada is a registered flop; it equals 1 exactly when the next state is not CHEIO.
- descarte (synchronous) has priority over everything except reset:
  - Next state is VAZIO and both slots are invalidated.
  - An input offered in the same cycle is discarded.
  - An output transfer in the same cycle still counts as completed.
- Reset (synchronous, any state, including mid-stall): state VAZIO, validoSaida=0, prontoEntrada=1, all data outputs 0, controle=11.
- Outputs are driven only from the output slot, never from instrucao directly.

Optional Feature:
- Macro DECODIFICADOR_ILEGAL_EN.
- When defined:
  - Adds output `ilegal` (1 bit), stored with the word.
  - `ilegal` is asserted for format 11 with bits[12:11] != 00, and for format 00 with opALU > 5'b10011.
  - Illegal words pass through with controle=11 and constante=0.
- When undefined:
  - No `ilegal` port.
  - Reserved bits are don't-care and all words are decoded per the format rules above.

Decomposition:
- Package pacote_decod holds:
  - Enum for controle codes: EXT_LOADLIT=00, EXT_LCL=01, EXT_LCH=10, EXT_NENHUM=11.
  - Enum for format codes.
  - Packed struct campos_decod_t: constante, controle, regA, regB, regC, opALU, ehALU, optional ilegal.
- One natural sub-module, decod_campos: purely combinational instrucao to campos_decod_t.
- The top level holds the skid FSM and the two campos_decod_t slots.

Test Plan:
- Reset, then loadlit 16'b10_101_11111111111 with prontoSaida=1 → next cycle validoSaida=1, regC=5, constante=11'h7FF, controle=00.
- lch 16'hE5A5 (11,1,00,101,10100101) then lcl 16'hC3A5 back-to-back → controle=10, regC=5, constante=11'h0A5; then controle=01, regC=3, constante=11'h0A5; one word per cycle, no bubbles.
- prontoSaida=0 while three words are offered → first two accepted, prontoEntrada=0 after the second; then prontoSaida=1 → words emerge in order, nothing lost or duplicated.
- CHEIO state, assert descarte with validoEntrada=1 → next cycle validoSaida=0, prontoEntrada=1, offered word never appears.
- Reset asserted while CHEIO and stalled → next cycle state VAZIO, all outputs 0, controle=11.
- ALU 16'h0A9A (op=00101, ra=2, rb=3, rc=2) → ehALU=1, opALU=5, regA=2, regB=3, regC=2, controle=11; with DECODIFICADOR_ILEGAL_EN, 16'h2800 (op=10100) → ilegal=1.
